calc_entry_ctrl: RTL
====================

# calc_entry_ctrl

Operand/operator entry controller for the keypad calculator. Consumes the single-cycle key events produced by the keypad synchronise/translate stages and assembles up to four BCD digits per operand, plus the operator. On `=` it hands both operands and the operator to the arithmetic stage over a req/ack handshake, then latches the BCD result. It selects the value the display stage shows.

## Interface
Parameters:
- `DIGITS`, 4: maximum BCD digits per operand. Operand width is 4*DIGITS bits.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `key_valid` in 1: one-cycle pulse, one translated key.
- `key_code` in 4: translated key, valid with `key_valid`.
  - 0–9: digits.
  - A: add; B: subtract; C: multiply.
  - D: equals; E: clear; F: backspace.
- `calc_req` out 1: operands/operator valid for the arithmetic stage.
- `calc_ack` in 1: arithmetic stage accepted the request.
- `calc_done` in 1: one-cycle pulse, result valid.
- `result_bcd` in 16: BCD result, sampled on `calc_done`.
- `operand_a` out 16: BCD operand A, most significant digit in [15:12].
- `operand_b` out 16: BCD operand B.
- `op` out 2: 00 add, 01 sub, 10 mul; 11 never driven.
- `display_state` out 2: 00 A, 01 operator, 10 B, 11 result.
- `disp_value` out 16: BCD value currently shown.
- `digit_count` out 3: digits entered in the active operand, 0..4.

## Operation
State machine states: ENTER_A, OP_SEL, ENTER_B, REQ, WAIT, SHOW. Reset state is ENTER_A.

- **ENTER_A**
  - Digit: if count<4, `operand_a <= {operand_a[11:0], d}` and count+1. If count==4, the digit is dropped and nothing changes.
  - Operator: latch `op`, clear count, go to OP_SEL. Count==0 is allowed; A is then 0.
  - `=`: ignored.
- **OP_SEL**
  - Operator: replaces `op`.
  - Digit: `operand_b <= {12'h0, d}`, count=1, go to ENTER_B.
  - `=`: ignored.
- **ENTER_B**
  - Digit: same shift/limit rule as ENTER_A.
  - Operator: ignored.
  - `=`: go to REQ.
- **REQ**
  - `calc_req`=1, with `operand_a`, `operand_b` and `op` held stable.
  - On `calc_ack`=1, go to WAIT. `calc_req` drops on the same edge.
- **WAIT**
  - On `calc_done`, latch `result_bcd` into an internal result register and go to SHOW.
- **SHOW**
  - Digit: A = digit, B = 0, count=1, go to ENTER_A.
  - Operator (chaining): `operand_a <= result`, latch `op`, count=0, go to OP_SEL.
  - `=`: ignored.
- **Clear (E), any state**
  - Operands, result, count and `op` go to 0. State goes to ENTER_A. `calc_req` goes to 0.
  - A `calc_done` arriving later in ENTER_A is ignored.
- **Keys in REQ/WAIT**: all dropped except clear.
- **Simultaneous events**
  - Clear and `calc_done` on the same edge: clear wins and the result is discarded.
  - `calc_done` in any state other than WAIT: ignored.
- **`disp_value` mux**
  - ENTER_A: `operand_a`.
  - OP_SEL: `operand_a`.
  - ENTER_B/REQ/WAIT: `operand_b`.
  - SHOW: result.
- **`display_state`**: 00 ENTER_A; 01 OP_SEL; 10 ENTER_B/REQ/WAIT; 11 SHOW.

## Timing
- All outputs are registered. Reset value of every output is 0, and state is ENTER_A.
- Key latency: a key sampled with `key_valid` at edge N is visible on the outputs after edge N.
- `=` at edge N makes `calc_req` high after edge N.
- `calc_ack` may already be high in the cycle `calc_req` rises. The transfer completes at the first edge where both are high.
- Minimum `=` to SHOW is 3 edges: REQ, WAIT, then `calc_done`.
- `key_valid` back-to-back on consecutive cycles: every key is processed.
- Reset assertion mid-handshake clears `calc_req` immediately, without waiting for a clock edge.

## Configuration
Macro `CALC_ENTRY_BACKSPACE_EN`.

- **Defined**, code F acts as backspace:
  - In ENTER_A or ENTER_B with count>0: operand shifts right one digit and count-1.
  - In ENTER_B with count==1: B becomes 0 and state returns to OP_SEL.
  - In ENTER_A with count==0, in OP_SEL, or in SHOW: ignored.
- **Undefined**: code F is ignored in every state, and no backspace logic is synthesised.

## Test plan
- **Reset and basic entry.** Reset, then keys 1,2,3 → `operand_a`=0x0123, `digit_count`=3, `display_state`=00, `disp_value`=0x0123.
- **Digit limit.** Keys 9,8,7,6,5 in ENTER_A → `operand_a`=0x9876; the fifth digit is dropped and `digit_count`=4.
- **Full calculation.** Keys 4,A,5,D → `op`=00, `operand_b`=0x0005, `calc_req`=1.
  - Hold `calc_ack` 0 for 3 cycles: `calc_req` stays 1 and the operands are stable.
  - Then ack, then `calc_done` with `result_bcd`=0x0009 → `display_state`=11, `disp_value`=0x0009.
- **Chaining from SHOW.** Key B → `operand_a`=0x0009, `op`=01, state OP_SEL.
  - Then C → `op`=10.
  - Then D → ignored; `calc_req` stays 0.
- **Clear mid-handshake.** Key E while in WAIT → all outputs 0, ENTER_A.
  - A `calc_done` 2 cycles later leaves `disp_value`=0 and `display_state`=00.
- **Backspace.** With `CALC_ENTRY_BACKSPACE_EN` defined: keys 1,2,F → `operand_a`=0x0001, count=1.
  - Undefined: the same keys → `operand_a`=0x0012.

Source files
------------

// File: rtl/calc_entry_ctrl.sv
// Keypad calculator entry controller: assembles BCD operands and the operator, hands them to the
// arithmetic stage over req/ack and latches the result. Optional backspace: CALC_ENTRY_BACKSPACE_EN.
module calc_entry_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  key_valid,
   input  logic [3:0]            key_code,
   output logic                  calc_req,
   input  logic                  calc_ack,
   input  logic                  calc_done,
   input  logic [4*DIGITS-1:0]   result_bcd,
   output logic [4*DIGITS-1:0]   operand_a,
   output logic [4*DIGITS-1:0]   operand_b,
   output logic [1:0]            op,
   output logic [1:0]            display_state,
   output logic [4*DIGITS-1:0]   disp_value,
   output logic [2:0]            digit_count
);

   localparam int W = 4 * DIGITS;

   typedef enum logic [2:0] {
      ENTER_A, OP_SEL, ENTER_B, REQ, WAIT, SHOW
   } state_t;

   state_t         state, nxt_state;
   logic [W-1:0]   result, nxt_result;
   logic [W-1:0]   nxt_a, nxt_b, nxt_dv;
   logic [1:0]     nxt_op, nxt_ds, key_op;
   logic [2:0]     nxt_count;
   logic           nxt_req;
   logic           is_digit, is_oper, is_eq, is_clr, room;

   assign is_digit = key_valid && (key_code <= 4'd9);
   assign is_oper  = key_valid && (key_code >= 4'hA) && (key_code <= 4'hC);
   assign is_eq    = key_valid && (key_code == 4'hD);
   assign is_clr   = key_valid && (key_code == 4'hE);
   assign key_op   = (key_code == 4'hA) ? 2'b00 : (key_code == 4'hB) ? 2'b01 : 2'b10;
   assign room     = digit_count < 3'(DIGITS);

   // Next-state computation; every output is registered from these next values.
   always_comb begin
      nxt_state  = state;
      nxt_a      = operand_a;
      nxt_b      = operand_b;
      nxt_op     = op;
      nxt_count  = digit_count;
      nxt_result = result;
      nxt_req    = calc_req;
      if (is_clr) begin
         nxt_state  = ENTER_A;
         nxt_a      = '0;
         nxt_b      = '0;
         nxt_op     = 2'b00;
         nxt_count  = 3'd0;
         nxt_result = '0;
         nxt_req    = 1'b0;
      end else begin
         case (state)
            ENTER_A: begin
               if (is_digit && room) begin
                  nxt_a     = {operand_a[W-5:0], key_code};
                  nxt_count = digit_count + 3'd1;
               end else if (is_oper) begin
                  nxt_op    = key_op;
                  nxt_count = 3'd0;
                  nxt_state = OP_SEL;
               end
`ifdef CALC_ENTRY_BACKSPACE_EN
               else if (key_valid && key_code == 4'hF && digit_count != 3'd0) begin
                  nxt_a     = {4'h0, operand_a[W-1:4]};
                  nxt_count = digit_count - 3'd1;
               end
`endif
            end
            OP_SEL: begin
               if (is_oper) begin
                  nxt_op = key_op;
               end else if (is_digit) begin
                  nxt_b     = {{(W-4){1'b0}}, key_code};
                  nxt_count = 3'd1;
                  nxt_state = ENTER_B;
               end
            end
            ENTER_B: begin
               if (is_digit && room) begin
                  nxt_b     = {operand_b[W-5:0], key_code};
                  nxt_count = digit_count + 3'd1;
               end else if (is_eq) begin
                  nxt_req   = 1'b1;
                  nxt_state = REQ;
               end
`ifdef CALC_ENTRY_BACKSPACE_EN
               // Erasing the only B digit falls back to operator selection.
               else if (key_valid && key_code == 4'hF) begin
                  if (digit_count <= 3'd1) begin
                     nxt_b     = '0;
                     nxt_count = 3'd0;
                     nxt_state = OP_SEL;
                  end else begin
                     nxt_b     = {4'h0, operand_b[W-1:4]};
                     nxt_count = digit_count - 3'd1;
                  end
               end
`endif
            end
            REQ: begin
               if (calc_ack) begin
                  nxt_req   = 1'b0;
                  nxt_state = WAIT;
               end
            end
            WAIT: begin
               if (calc_done) begin
                  nxt_result = result_bcd;
                  nxt_state  = SHOW;
               end
            end
            SHOW: begin
               if (is_digit) begin
                  nxt_a     = {{(W-4){1'b0}}, key_code};
                  nxt_b     = '0;
                  nxt_count = 3'd1;
                  nxt_state = ENTER_A;
               end else if (is_oper) begin
                  nxt_a     = result;
                  nxt_op    = key_op;
                  nxt_count = 3'd0;
                  nxt_state = OP_SEL;
               end
            end
            default: nxt_state = ENTER_A;
         endcase
      end
   end

   // Display selection follows the state being entered, so it lines up with the registered data.
   always_comb begin
      nxt_ds = 2'b10;
      nxt_dv = nxt_b;
      case (nxt_state)
         ENTER_A: begin nxt_ds = 2'b00; nxt_dv = nxt_a;      end
         OP_SEL:  begin nxt_ds = 2'b01; nxt_dv = nxt_a;      end
         SHOW:    begin nxt_ds = 2'b11; nxt_dv = nxt_result; end
         default: begin nxt_ds = 2'b10; nxt_dv = nxt_b;      end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= ENTER_A;
         operand_a     <= '0;
         operand_b     <= '0;
         op            <= 2'b00;
         digit_count   <= 3'd0;
         result        <= '0;
         calc_req      <= 1'b0;
         display_state <= 2'b00;
         disp_value    <= '0;
      end else begin
         state         <= nxt_state;
         operand_a     <= nxt_a;
         operand_b     <= nxt_b;
         op            <= nxt_op;
         digit_count   <= nxt_count;
         result        <= nxt_result;
         calc_req      <= nxt_req;
         display_state <= nxt_ds;
         disp_value    <= nxt_dv;
      end
   end

endmodule
